reorder_buffer: RTL and testbench

Storage half of the reorder buffer. It is a circular queue of in-flight instructions.
- The ROB stage allocates entries through the write channel and retires them through the commit channel.
- Execution units mark entries complete through a result port.
- Issue logic resolves operand references through two read ports.
- Sits between the ROB stage, the execution/CDB writeback and the pipeline controller's flush.

---
 rtl/reorder_buffer_if.sv | 66 ++++++
 rtl/reorder_buffer.sv | 112 +++++++++++
 tb/tb_reorder_buffer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Reorder buffer channels: allocate/commit from the ROB stage, result from writeback, operand lookups from issue.
// Master drives requests; slave is the buffer. Back-pressure is exposed through can_write and can_commit.
interface reorder_buffer_if #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int EXC_WIDTH      = 4
);
    logic                      flush;

    logic                      write_en;
    logic                      can_write;
    logic [ADDR_WIDTH-1:0]     write_addr;
    logic                      write_reg_write_en;
    logic [REG_ADDR_WIDTH-1:0] write_reg_write_addr;
    logic [EXC_WIDTH-1:0]      write_exception_type;
    logic                      write_is_delayslot;
    logic [DATA_WIDTH-1:0]     write_pc;

    logic                      commit_en;
    logic                      can_commit;
    logic                      commit_reg_write_en;
    logic [REG_ADDR_WIDTH-1:0] commit_reg_write_addr;
    logic [DATA_WIDTH-1:0]     commit_reg_write_data;
    logic [EXC_WIDTH-1:0]      commit_exception_type;
    logic                      commit_is_delayslot;
    logic [DATA_WIDTH-1:0]     commit_pc;

    logic                      result_en;
    logic [ADDR_WIDTH-1:0]     result_addr;
    logic [DATA_WIDTH-1:0]     result_data;
    logic [EXC_WIDTH-1:0]      result_exception_type;

    logic [ADDR_WIDTH-1:0]     read_addr_1;
    logic [ADDR_WIDTH-1:0]     read_addr_2;
    logic                      read_ready_1;
    logic                      read_ready_2;
    logic [DATA_WIDTH-1:0]     read_data_1;
    logic [DATA_WIDTH-1:0]     read_data_2;

    modport master (
        output flush,
        output write_en, write_reg_write_en, write_reg_write_addr,
        output write_exception_type, write_is_delayslot, write_pc,
        input  can_write, write_addr,
        output commit_en,
        input  can_commit, commit_reg_write_en, commit_reg_write_addr,
        input  commit_reg_write_data, commit_exception_type, commit_is_delayslot, commit_pc,
        output result_en, result_addr, result_data, result_exception_type,
        output read_addr_1, read_addr_2,
        input  read_ready_1, read_ready_2, read_data_1, read_data_2
    );

    modport slave (
        input  flush,
        input  write_en, write_reg_write_en, write_reg_write_addr,
        input  write_exception_type, write_is_delayslot, write_pc,
        output can_write, write_addr,
        input  commit_en,
        output can_commit, commit_reg_write_en, commit_reg_write_addr,
        output commit_reg_write_data, commit_exception_type, commit_is_delayslot, commit_pc,
        input  result_en, result_addr, result_data, result_exception_type,
        input  read_addr_1, read_addr_2,
        output read_ready_1, read_ready_2, read_data_1, read_data_2
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-flight instruction queue; state updates one cycle after the request, reads/status are combinational.
// Back-pressure: writes blocked while full (no same-cycle reuse of a committing slot); commit only when head is done.
module reorder_buffer #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int EXC_WIDTH      = 4
) (
    input  logic               clk,
    input  logic               rst,
    reorder_buffer_if.slave    bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

    typedef struct packed {
        logic                      reg_write_en;
        logic [REG_ADDR_WIDTH-1:0] reg_write_addr;
        logic [DATA_WIDTH-1:0]     data;
        logic [EXC_WIDTH-1:0]      exception_type;
        logic                      is_delayslot;
        logic [DATA_WIDTH-1:0]     pc;
    } entry_t;

    entry_t              entries [DEPTH];
    logic [DEPTH-1:0]    valid;
    logic [DEPTH-1:0]    done;
    logic [ADDR_WIDTH:0] head;
    logic [ADDR_WIDTH:0] tail;

    logic [ADDR_WIDTH-1:0] head_idx;
    logic [ADDR_WIDTH-1:0] tail_idx;
    logic                  empty;
    logic                  full;
    logic                  do_write;
    logic                  do_commit;
    logic                  do_result;
    entry_t                head_entry;

    assign head_idx  = head[ADDR_WIDTH-1:0];
    assign tail_idx  = tail[ADDR_WIDTH-1:0];
    assign empty     = (head == tail);
    assign full      = (head_idx == tail_idx) && (head[ADDR_WIDTH] != tail[ADDR_WIDTH]);
    assign do_write  = bus.write_en && !full;
    assign do_commit = bus.commit_en && bus.can_commit;
    assign do_result = bus.result_en && valid[bus.result_addr];
    assign head_entry = entries[head_idx];

    assign bus.can_write  = !full;
    assign bus.write_addr = tail_idx;
    assign bus.can_commit = valid[head_idx] && done[head_idx];

    assign bus.commit_reg_write_en   = empty ? 1'b0 : head_entry.reg_write_en;
    assign bus.commit_reg_write_addr = empty ? '0   : head_entry.reg_write_addr;
    assign bus.commit_reg_write_data = empty ? '0   : head_entry.data;
    assign bus.commit_exception_type = empty ? '0   : head_entry.exception_type;
    assign bus.commit_is_delayslot   = empty ? 1'b0 : head_entry.is_delayslot;
    assign bus.commit_pc             = empty ? '0   : head_entry.pc;

    // Operand lookup sees an in-flight result in the same cycle it is written back.
    logic byp_1, byp_2, rdy_1, rdy_2;
    assign byp_1 = bus.result_en && (bus.result_addr == bus.read_addr_1) && valid[bus.read_addr_1];
    assign byp_2 = bus.result_en && (bus.result_addr == bus.read_addr_2) && valid[bus.read_addr_2];
    assign rdy_1 = valid[bus.read_addr_1] && done[bus.read_addr_1];
    assign rdy_2 = valid[bus.read_addr_2] && done[bus.read_addr_2];

    assign bus.read_ready_1 = byp_1 || rdy_1;
    assign bus.read_ready_2 = byp_2 || rdy_2;
    assign bus.read_data_1  = byp_1 ? bus.result_data : (rdy_1 ? entries[bus.read_addr_1].data : '0);
    assign bus.read_data_2  = byp_2 ? bus.result_data : (rdy_2 ? entries[bus.read_addr_2].data : '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            valid <= '0;
            done  <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (bus.flush) begin
            head  <= '0;
            tail  <= '0;
            valid <= '0;
            done  <= '0;
        end else begin
            if (do_result) begin
                entries[bus.result_addr].data <= bus.result_data;
                done[bus.result_addr]         <= 1'b1;
                // The earliest detected exception wins.
                if (entries[bus.result_addr].exception_type == '0)
                    entries[bus.result_addr].exception_type <= bus.result_exception_type;
            end
            if (do_write) begin
                entries[tail_idx] <= '{
                    reg_write_en:   bus.write_reg_write_en,
                    reg_write_addr: bus.write_reg_write_addr,
                    data:           '0,
                    exception_type: bus.write_exception_type,
                    is_delayslot:   bus.write_is_delayslot,
                    pc:             bus.write_pc
                };
                valid[tail_idx] <= 1'b1;
                done[tail_idx]  <= (bus.write_exception_type != '0);
                tail            <= tail + PTR_ONE;
            end
            if (do_commit) begin
                valid[head_idx] <= 1'b0;
                done[head_idx]  <= 1'b0;
                head            <= head + PTR_ONE;
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with hand-computed expectations.
module tb_reorder_buffer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    reorder_buffer_if bus();

    reorder_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush                 = 1'b0;
        bus.write_en              = 1'b0;
        bus.write_reg_write_en    = 1'b0;
        bus.write_reg_write_addr  = '0;
        bus.write_exception_type  = '0;
        bus.write_is_delayslot    = 1'b0;
        bus.write_pc              = '0;
        bus.commit_en             = 1'b0;
        bus.result_en             = 1'b0;
        bus.result_addr           = '0;
        bus.result_data           = '0;
        bus.result_exception_type = '0;
        bus.read_addr_1           = '0;
        bus.read_addr_2           = '0;
    endtask

    task automatic wr(input logic [4:0] rd, input logic [3:0] exc, input logic ds, input logic [31:0] pc);
        bus.write_en             = 1'b1;
        bus.write_reg_write_en   = 1'b1;
        bus.write_reg_write_addr = rd;
        bus.write_exception_type = exc;
        bus.write_is_delayslot   = ds;
        bus.write_pc             = pc;
        tick();
        bus.write_en             = 1'b0;
        bus.write_exception_type = '0;
        bus.write_is_delayslot   = 1'b0;
    endtask

    task automatic res(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] exc);
        bus.result_en             = 1'b1;
        bus.result_addr           = addr;
        bus.result_data           = data;
        bus.result_exception_type = exc;
        tick();
        bus.result_en             = 1'b0;
    endtask

    task automatic commit();
        bus.commit_en = 1'b1;
        tick();
        bus.commit_en = 1'b0;
    endtask

    task automatic flush_all();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;

        // Reset state
        chk_eq("rst_can_write", bus.can_write, 1);
        chk_eq("rst_write_addr", bus.write_addr, 0);
        chk_eq("rst_can_commit", bus.can_commit, 0);
        chk_eq("rst_commit_pc", bus.commit_pc, 0);
        chk_eq("rst_commit_rd", bus.commit_reg_write_addr, 0);
        chk_eq("rst_read_ready_1", bus.read_ready_1, 0);
        chk_eq("rst_read_data_1", bus.read_data_1, 0);

        // Fill to full, then an ignored write
        for (int i = 0; i < 16; i++) begin
            chk_eq($sformatf("fill_addr_%0d", i), bus.write_addr, i);
            chk_eq($sformatf("fill_can_write_%0d", i), bus.can_write, 1);
            wr(5'd1, 4'd0, 1'b0, 32'h100 + 32'(i * 4));
        end
        chk_eq("full_can_write", bus.can_write, 0);
        chk_eq("full_can_commit", bus.can_commit, 0);
        wr(5'd2, 4'd0, 1'b0, 32'hDEAD);
        chk_eq("overfill_write_addr", bus.write_addr, 0);
        chk_eq("overfill_can_write", bus.can_write, 0);
        flush_all();
        chk_eq("flush1_can_write", bus.can_write, 1);
        chk_eq("flush1_write_addr", bus.write_addr, 0);

        // Basic allocate / result / commit; result does not bypass into can_commit
        wr(5'd5, 4'd0, 1'b0, 32'hBFC00000);
        chk_eq("pending_can_commit", bus.can_commit, 0);
        bus.result_en   = 1'b1;
        bus.result_addr = 4'd0;
        bus.result_data = 32'h1234;
        #1;
        chk_eq("no_bypass_can_commit", bus.can_commit, 0);
        tick();
        bus.result_en = 1'b0;
        chk_eq("done_can_commit", bus.can_commit, 1);
        chk_eq("done_commit_rd", bus.commit_reg_write_addr, 5);
        chk_eq("done_commit_data", bus.commit_reg_write_data, 32'h1234);
        chk_eq("done_commit_pc", bus.commit_pc, 32'hBFC00000);
        chk_eq("done_commit_we", bus.commit_reg_write_en, 1);
        commit();
        chk_eq("drained_can_commit", bus.can_commit, 0);
        chk_eq("drained_commit_pc", bus.commit_pc, 0);
        chk_eq("drained_write_addr", bus.write_addr, 1);

        // Exception at allocation: done immediately, first exception kept
        wr(5'd7, 4'd3, 1'b1, 32'h200);
        chk_eq("exc_can_commit", bus.can_commit, 1);
        chk_eq("exc_type", bus.commit_exception_type, 3);
        chk_eq("exc_delayslot", bus.commit_is_delayslot, 1);
        res(4'd1, 32'h55, 4'd5);
        chk_eq("exc_type_kept", bus.commit_exception_type, 3);
        chk_eq("exc_result_data", bus.commit_reg_write_data, 32'h55);
        commit();

        // Read ports: unfinished entry, same-cycle bypass, invalid entry
        wr(5'd8, 4'd0, 1'b0, 32'h300);
        wr(5'd9, 4'd0, 1'b0, 32'h304);
        bus.read_addr_1 = 4'd2;
        bus.read_addr_2 = 4'd3;
        #1;
        chk_eq("unfinished_ready", bus.read_ready_1, 0);
        chk_eq("unfinished_data", bus.read_data_1, 0);
        bus.commit_en = 1'b1;
        tick();
        bus.commit_en = 1'b0;
        chk_eq("ignored_commit_addr", bus.write_addr, 4);
        chk_eq("ignored_commit_pc", bus.commit_pc, 32'h300);
        bus.result_en   = 1'b1;
        bus.result_addr = 4'd2;
        bus.result_data = 32'hCAFE;
        #1;
        chk_eq("bypass_ready_1", bus.read_ready_1, 1);
        chk_eq("bypass_data_1", bus.read_data_1, 32'hCAFE);
        chk_eq("bypass_ready_2", bus.read_ready_2, 0);
        tick();
        bus.result_en = 1'b0;
        chk_eq("stored_ready_1", bus.read_ready_1, 1);
        chk_eq("stored_data_1", bus.read_data_1, 32'hCAFE);
        chk_eq("stored_commit_data", bus.commit_reg_write_data, 32'hCAFE);
        bus.result_en   = 1'b1;
        bus.result_addr = 4'd9;
        bus.read_addr_2 = 4'd9;
        #1;
        chk_eq("invalid_bypass_ready", bus.read_ready_2, 0);
        bus.result_en = 1'b0;
        commit();
        res(4'd3, 32'h77, 4'd0);
        commit();
        chk_eq("empty_again_addr", bus.write_addr, 4);
        chk_eq("empty_again_commit", bus.can_commit, 0);

        // Wrap: 12 entries from index 4 through 15, drain, refill to full
        for (int i = 0; i < 12; i++) begin
            chk_eq($sformatf("wrap_addr_%0d", i), bus.write_addr, (4 + i) % 16);
            wr(5'd3, 4'd1, 1'b0, 32'h1000 + 32'(i * 4));
        end
        chk_eq("wrap_tail_zero", bus.write_addr, 0);
        chk_eq("wrap_can_write", bus.can_write, 1);
        for (int i = 0; i < 12; i++) begin
            chk_eq($sformatf("drain_pc_%0d", i), bus.commit_pc, 32'h1000 + 32'(i * 4));
            commit();
        end
        chk_eq("wrap_empty_commit", bus.can_commit, 0);
        chk_eq("wrap_empty_write", bus.can_write, 1);
        for (int i = 0; i < 16; i++) begin
            chk_eq($sformatf("refill_addr_%0d", i), bus.write_addr, i);
            wr(5'd4, 4'd1, 1'b0, 32'h2000 + 32'(i * 4));
        end
        chk_eq("refill_full", bus.can_write, 0);
        chk_eq("refill_head_pc", bus.commit_pc, 32'h2000);

        // Write+commit while full: commit only, freed slot not reused this cycle
        bus.write_exception_type = 4'd1;
        bus.write_pc  = 32'h3000;
        bus.write_en  = 1'b1;
        bus.commit_en = 1'b1;
        tick();
        chk_eq("full_wc_can_write", bus.can_write, 1);
        chk_eq("full_wc_write_addr", bus.write_addr, 0);
        chk_eq("full_wc_head_pc", bus.commit_pc, 32'h2004);
        tick();
        bus.write_en  = 1'b0;
        bus.commit_en = 1'b0;
        chk_eq("wc_write_addr", bus.write_addr, 1);
        chk_eq("wc_can_write", bus.can_write, 1);
        chk_eq("wc_head_pc", bus.commit_pc, 32'h2008);

        // Flush beats write, commit and result on a 5-entry buffer
        flush_all();
        for (int i = 0; i < 5; i++) wr(5'd6, 4'd1, 1'b0, 32'h4000 + 32'(i * 4));
        chk_eq("five_write_addr", bus.write_addr, 5);
        bus.flush       = 1'b1;
        bus.write_en    = 1'b1;
        bus.commit_en   = 1'b1;
        bus.result_en   = 1'b1;
        bus.result_addr = 4'd1;
        tick();
        idle();
        chk_eq("flush_can_commit", bus.can_commit, 0);
        chk_eq("flush_can_write", bus.can_write, 1);
        chk_eq("flush_write_addr", bus.write_addr, 0);
        chk_eq("flush_commit_pc", bus.commit_pc, 0);
        chk_eq("flush_read_ready", bus.read_ready_1, 0);

        // Reset mid-operation
        wr(5'd10, 4'd2, 1'b0, 32'h5000);
        wr(5'd11, 4'd2, 1'b0, 32'h5004);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk_eq("midrst_write_addr", bus.write_addr, 0);
        chk_eq("midrst_can_commit", bus.can_commit, 0);
        chk_eq("midrst_read_ready", bus.read_ready_1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
